// File: rtl/curve_regbank.sv
// rtl/curve_regbank.sv - byte-addressed operand/result register bank and start/done sequencer for a wide crypto core
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   subaddr       byte subaddress from the I2C slave
//   wr_data       write byte
//   wr_pulse      one-cycle write strobe
//   rd_data       registered read byte (mux of subaddr, 1-cycle latency)
//   rd_pulse      one-cycle strobe: byte consumed by the I2C master
//   core_operands NUM_IN input words, word i at [i*W +: W], little-endian bytes
//   core_start    one-cycle start pulse to the core
//   core_done     one-cycle completion pulse from the core
//   core_result   NUM_OUT result words, valid while core_done is high
//   done_int      level interrupt, done & irq_en registered

module curve_regbank #(
  parameter int          WORD_BYTES     = 32,
  parameter int          NUM_IN         = 2,
  parameter int          NUM_OUT        = 1,
  parameter int          DONE_RTC       = 0,
  parameter int          TIMEOUT_CYCLES = 0,
  parameter logic [7:0]  VERSION        = 8'h21
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     subaddr,
  input  logic [7:0]                     wr_data,
  input  logic                           wr_pulse,
  output logic [7:0]                     rd_data,
  input  logic                           rd_pulse,
  output logic [NUM_IN*8*WORD_BYTES-1:0]  core_operands,
  output logic                           core_start,
  input  logic                           core_done,
  input  logic [NUM_OUT*8*WORD_BYTES-1:0] core_result,
  output logic                           done_int
);

  localparam int IN_BYTES  = NUM_IN * WORD_BYTES;
  localparam int OUT_BYTES = NUM_OUT * WORD_BYTES;
  localparam int IN_AW     = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam int OUT_AW    = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam logic [8:0] IN_END  = 9'(IN_BYTES);
  localparam logic [8:0] OUT_END = 9'(IN_BYTES + OUT_BYTES);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The counter starts at 0 on entry to RUN, so the edge that sees TO_LAST
  // is the TIMEOUT_CYCLES-th cycle of RUN.
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [7:0] ADDR_CTRL    = 8'hF0;
  localparam logic [7:0] ADDR_STATUS  = 8'hF1;
  localparam logic [7:0] ADDR_VERSION = 8'hF2;

  // Operand and result windows must stay below the 0xF0 control block.
  if ((NUM_IN + NUM_OUT) * WORD_BYTES > 240) begin : g_param_check
    $error("curve_regbank: operand/result space overlaps the control registers");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state;
  logic [7:0]      op_mem  [IN_BYTES];
  logic [7:0]      res_mem [OUT_BYTES];
  logic            irq_en;
  logic            done;
  logic            err;
  logic [TW-1:0]   to_cnt;

  logic              in_sel, out_sel, running;
  logic              wr_in, wr_ctrl, wr_stat, start_req, rtc_clr;
  logic              timeout_hit, count_en;
  logic              done_set, err_set, done_clr, err_clr;
  logic [IN_AW-1:0]  in_idx;
  logic [OUT_AW-1:0] res_idx;
  logic [7:0]        rd_next;

  for (genvar b = 0; b < IN_BYTES; b++) begin : g_ops
    assign core_operands[b*8 +: 8] = op_mem[b];
  end

  always_comb begin
    running     = (state == S_RUN);
    in_sel      = ({1'b0, subaddr} < IN_END);
    out_sel     = !in_sel && ({1'b0, subaddr} < OUT_END);
    in_idx      = subaddr[IN_AW-1:0];
    res_idx     = OUT_AW'(subaddr - 8'(IN_BYTES));
    wr_in       = wr_pulse && in_sel;
    wr_ctrl     = wr_pulse && (subaddr == ADDR_CTRL);
    wr_stat     = wr_pulse && (subaddr == ADDR_STATUS);
    start_req   = wr_ctrl && wr_data[0];
    rtc_clr     = (DONE_RTC != 0) && rd_pulse && (subaddr == ADDR_STATUS);
    // A completion in the same cycle as the watchdog expiring counts as done.
    timeout_hit = (TIMEOUT_CYCLES > 0) && running && !core_done && (to_cnt == TO_LAST);
    count_en    = (TIMEOUT_CYCLES > 0) && running && !core_done && !timeout_hit;
    done_set    = running && core_done;
    // Operand writes and restarts while busy are dropped and flagged.
    err_set     = (running && (wr_in || start_req)) || timeout_hit;
    done_clr    = (wr_stat && wr_data[1]) || rtc_clr;
    err_clr     = (wr_stat && wr_data[2]) || rtc_clr;

    rd_next = 8'h00;
    if (in_sel)
      rd_next = op_mem[in_idx];
    else if (out_sel)
      rd_next = res_mem[res_idx];
    else if (subaddr == ADDR_CTRL)
      rd_next = {6'b0, irq_en, 1'b0};
    else if (subaddr == ADDR_STATUS)
      rd_next = {5'b0, err, done, running};
    else if (subaddr == ADDR_VERSION)
      rd_next = VERSION;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      for (int b = 0; b < IN_BYTES; b++)  op_mem[b]  <= 8'h00;
      for (int b = 0; b < OUT_BYTES; b++) res_mem[b] <= 8'h00;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      to_cnt     <= '0;
      rd_data    <= 8'h00;
      core_start <= 1'b0;
      done_int   <= 1'b0;
    end else begin
      core_start <= 1'b0;
      rd_data    <= rd_next;
      done_int   <= done & irq_en;
      // Hardware set takes priority over software clear.
      done       <= done_set | (done & ~done_clr);
      err        <= err_set | (err & ~err_clr);
      to_cnt     <= count_en ? to_cnt + 1'b1 : '0;
      if (wr_in && !running)
        op_mem[in_idx] <= wr_data;
      if (wr_ctrl)
        irq_en <= wr_data[1];
      case (state)
        S_IDLE: begin
          if (start_req) begin
            core_start <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (core_done) begin
            for (int b = 0; b < OUT_BYTES; b++)
              res_mem[b] <= core_result[b*8 +: 8];
            state <= S_IDLE;
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_curve_regbank.sv
// tb/tb_curve_regbank.sv - randomized self-checking bench for curve_regbank against a behavioural model
module tb_curve_regbank;
  localparam int WB  = 32;
  localparam int NI  = 2;
  localparam int NO  = 1;
  localparam int RTC = 1;
  localparam int TO  = 10;
  localparam int WW  = 8 * WB;
  localparam int IB  = NI * WB;
  localparam int OB  = NO * WB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b0;
  logic [7:0]        subaddr = 8'h00;
  logic [7:0]        wr_data = 8'h00;
  logic              wr_pulse = 1'b0;
  logic              rd_pulse = 1'b0;
  logic              core_done = 1'b0;
  logic [NO*WW-1:0]  core_result = '0;
  logic [7:0]        rd_data;
  logic [NI*WW-1:0]  core_operands;
  logic              core_start;
  logic              done_int;

  curve_regbank #(
    .WORD_BYTES(WB), .NUM_IN(NI), .NUM_OUT(NO),
    .DONE_RTC(RTC), .TIMEOUT_CYCLES(TO), .VERSION(8'h21)
  ) dut (
    .clk(clk), .reset(reset), .subaddr(subaddr), .wr_data(wr_data),
    .wr_pulse(wr_pulse), .rd_data(rd_data), .rd_pulse(rd_pulse),
    .core_operands(core_operands), .core_start(core_start),
    .core_done(core_done), .core_result(core_result), .done_int(done_int)
  );

  int tests = 0;
  int fails = 0;
  int starts_seen = 0;

  // Behavioural model state
  logic [7:0]       m_op  [IB];
  logic [7:0]       m_res [OB];
  bit               m_irq, m_done, m_err, m_run;
  int               m_cnt;
  logic [7:0]       e_rd;
  bit               e_start, e_dint;
  logic [NI*WW-1:0] e_ops;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [NI*WW-1:0] act, input logic [NI*WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input int a);
    if (a < IB)           return m_op[a];
    else if (a < IB + OB) return m_res[a - IB];
    else if (a == 240)    return {6'b0, m_irq, 1'b0};
    else if (a == 241)    return {5'b0, m_err, m_done, m_run};
    else if (a == 242)    return 8'h21;
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < IB; i++) m_op[i] = 8'h00;
    for (int i = 0; i < OB; i++) m_res[i] = 8'h00;
    m_irq = 0; m_done = 0; m_err = 0; m_run = 0; m_cnt = 0;
    e_rd = 8'h00; e_start = 0; e_dint = 0; e_ops = '0;
  endtask

  // Predicts the effect of the next rising edge from the inputs now applied.
  task automatic model_step();
    int a;
    bit ds, es, cd, ce, st;
    if (!reset) begin
      model_reset();
      return;
    end
    a = int'(subaddr);
    ds = 0; es = 0; cd = 0; ce = 0; st = 0;
    e_rd   = m_read(a);
    e_dint = m_done && m_irq;
    if (wr_pulse) begin
      if (a < IB) begin
        if (m_run) es = 1; else m_op[a] = wr_data;
      end else if (a == 240) begin
        m_irq = wr_data[1];
        if (wr_data[0]) begin
          if (m_run) es = 1; else st = 1;
        end
      end else if (a == 241) begin
        cd = wr_data[1];
        ce = wr_data[2];
      end
    end
    if (RTC != 0 && rd_pulse && a == 241) begin
      cd = 1; ce = 1;
    end
    if (m_run) begin
      if (core_done) begin
        for (int b = 0; b < OB; b++) m_res[b] = core_result[b*8 +: 8];
        ds = 1;
        m_run = 0;
      end else begin
        m_cnt++;
        if (m_cnt == TO) begin
          es = 1;
          m_run = 0;
        end
      end
    end
    if (st) begin
      m_run = 1;
      m_cnt = 0;
    end
    m_done  = ds || (m_done && !cd);
    m_err   = es || (m_err && !ce);
    e_start = st;
    for (int b = 0; b < IB; b++) e_ops[b*8 +: 8] = m_op[b];
  endtask

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(posedge clk);
    #2;
    chk8("rd_data", rd_data, e_rd);
    chk8("core_start", 8'(core_start), 8'(e_start));
    chk8("done_int", 8'(done_int), 8'(e_dint));
    chkw("core_operands", core_operands, e_ops);
    if (core_start) starts_seen++;
  end

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    subaddr = a; wr_data = d; wr_pulse = 1'b1;
    step();
    wr_pulse = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    subaddr = a;
    model_step();
    @(posedge clk);
    #3 v = rd_data;
    @(negedge clk);
  endtask

  task automatic rdp(input logic [7:0] a, output logic [7:0] v);
    subaddr = a; rd_pulse = 1'b1;
    model_step();
    @(posedge clk);
    #3 v = rd_data;
    @(negedge clk);
    rd_pulse = 1'b0;
  endtask

  task automatic cdone(input logic [NO*WW-1:0] r);
    core_result = r; core_done = 1'b1;
    step();
    core_done = 1'b0;
  endtask

  task automatic rand_result();
    for (int w = 0; w < NO * WW / 32; w++) core_result[w*32 +: 32] = $urandom();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int r;
    model_reset();
    @(negedge clk);
    step();
    step();
    chk8("reset_rd_data", rd_data, 8'h00);
    chk8("reset_done_int", 8'(done_int), 8'h00);
    chkw("reset_operands", core_operands, '0);
    reset = 1'b1;

    // Defaults
    for (int i = 0; i < 64; i++) wr(8'(i), 8'(i));
    wr(8'hF0, 8'h03);
    chk8("start_count_1", 8'(starts_seen), 8'd1);
    chk8("op_byte0", core_operands[7:0], 8'h00);
    chk8("op_word1_byte0", core_operands[WW+7:WW], 8'h20);
    rd(8'hF1, v); chk8("status_running", v, 8'h01);

    // Completion
    cdone({OB{8'hA5}});
    rd(8'hF1, v); chk8("status_done", v, 8'h02);
    chk8("done_int_high", 8'(done_int), 8'h01);
    rd(8'h40, v); chk8("result_first", v, 8'hA5);
    rd(8'h5F, v); chk8("result_last", v, 8'hA5);
    wr(8'hF1, 8'h02);
    rd(8'hF1, v); chk8("status_cleared", v, 8'h00);
    chk8("done_int_low", 8'(done_int), 8'h00);

    // Busy lock
    wr(8'hF0, 8'h01);
    wr(8'h00, 8'hFF);
    wr(8'hF0, 8'h01);
    rd(8'h00, v); chk8("locked_operand", v, 8'h00);
    rd(8'hF1, v); chk8("status_busy_err", v, 8'h05);
    chk8("start_count_2", 8'(starts_seen), 8'd2);
    rand_result();
    cdone(core_result);
    wr(8'hF1, 8'h06);

    // Timeout
    wr(8'hF0, 8'h03);
    subaddr = 8'hF1;
    for (int k = 1; k <= 11; k++) begin
      model_step();
      @(posedge clk);
      #3;
      if (k == 10) chk8("timeout_still_busy", rd_data, 8'h01);
      if (k == 11) chk8("timeout_status", rd_data, 8'h04);
      @(negedge clk);
    end
    chk8("timeout_no_irq", 8'(done_int), 8'h00);
    wr(8'hF1, 8'h04);

    // Done collides with W1C, then read-to-clear
    wr(8'hF0, 8'h03);
    rand_result();
    subaddr = 8'hF1; wr_data = 8'h02; wr_pulse = 1'b1; core_done = 1'b1;
    step();
    wr_pulse = 1'b0; core_done = 1'b0;
    rdp(8'hF1, v); chk8("rtc_read_value", v, 8'h02);
    rd(8'hF1, v); chk8("rtc_after_clear", v, 8'h00);

    // Reset mid-RUN and unmapped space
    wr(8'hF0, 8'h01);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #3;
    chk8("midrun_rd_data", rd_data, 8'h00);
    chk8("midrun_core_start", 8'(core_start), 8'h00);
    chk8("midrun_done_int", 8'(done_int), 8'h00);
    chkw("midrun_operands", core_operands, '0);
    @(negedge clk);
    reset = 1'b1;
    rd(8'hE0, v); chk8("unmapped_e0", v, 8'h00);
    rd(8'hF5, v); chk8("unmapped_f5", v, 8'h00);
    rd(8'hF2, v); chk8("version", v, 8'h21);
    rd(8'hF1, v); chk8("status_after_reset", v, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: subaddr = 8'($urandom_range(0, IB - 1));
        4:          subaddr = 8'($urandom_range(IB, IB + OB - 1));
        5:          subaddr = 8'hF0;
        6, 7:       subaddr = 8'hF1;
        8:          subaddr = 8'hF2;
        default:    subaddr = 8'($urandom_range(0, 255));
      endcase
      wr_data   = 8'($urandom_range(0, 255));
      wr_pulse  = ($urandom_range(0, 2) == 0);
      rd_pulse  = ($urandom_range(0, 3) == 0);
      core_done = ($urandom_range(0, 11) == 0);
      rand_result();
      reset     = ($urandom_range(0, 199) != 0);
      if (!reset) model_reset();
      step();
    end
    reset = 1'b1; wr_pulse = 1'b0; rd_pulse = 1'b0; core_done = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
